// File: rtl/legv8_control_fsm.sv
`timescale 1ns/1ps
// Multi-cycle LEGv8 control unit: FETCH -> DECODE -> EX [-> MEM | BR_TEST], plus a terminal HALT state.
// State is registered; the control word, k, instr_done and halted are decoded from state, IR, status and mem_ready.
module legv8_control_fsm #(
    parameter logic [4:0] FS_ADD     = 5'b01000,
    parameter logic [4:0] FS_SUB     = 5'b01001,
    parameter logic [4:0] FS_AND     = 5'b00000,
    parameter logic [4:0] FS_ORR     = 5'b00100,
    parameter logic [4:0] FS_PASSB   = 5'b10100,
    parameter logic [1:0] MEM_CS_ROM = 2'b10,
    parameter logic [1:0] MEM_CS_RAM = 2'b01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic [3:0]  status,
    input  logic        mem_ready,
    output logic [35:0] controlWord,
    output logic [63:0] k,
    output logic        instr_done,
    output logic        halted
);
    typedef struct packed {
        logic [4:0] fs;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] da;
        logic       w_reg;
        logic       c0;
        logic [1:0] mem_cs;
        logic       b_sel;
        logic       mem_write_en;
        logic       ir_load;
        logic       status_load;
        logic [1:0] size;
        logic       add_tri_sel;
        logic [1:0] data_tri_sel;
        logic       pc_sel;
        logic [1:0] pc_fs;
    } cw_t;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EX, S_MEM, S_BR_TEST, S_HALT} state_t;
    typedef enum logic [3:0] {
        C_ADD, C_SUB, C_AND, C_ORR, C_ADDS, C_SUBS, C_ADDI, C_SUBI,
        C_LDUR, C_STUR, C_B, C_CBZ, C_BCOND, C_ILL
    } cls_t;

    state_t r_state;
    cls_t   r_cls;
    cls_t   w_dec_cls;
    logic   w_cond;
    cw_t    w_cw;
    logic [63:0] w_k;
    logic   w_done;

    always_comb begin
        w_dec_cls = C_ILL;
        if      (IR[31:26] == 6'b000101)   w_dec_cls = C_B;
        else if (IR[31:24] == 8'b10110100) w_dec_cls = C_CBZ;
        else if (IR[31:24] == 8'b01010100) w_dec_cls = C_BCOND;
        else if (IR[31:22] == 10'b1001000100) w_dec_cls = C_ADDI;
        else if (IR[31:22] == 10'b1101000100) w_dec_cls = C_SUBI;
        else begin
            case (IR[31:21])
                11'b10001011000: w_dec_cls = C_ADD;
                11'b11001011000: w_dec_cls = C_SUB;
                11'b10001010000: w_dec_cls = C_AND;
                11'b10101010000: w_dec_cls = C_ORR;
                11'b10101011000: w_dec_cls = C_ADDS;
                11'b11101011000: w_dec_cls = C_SUBS;
                11'b11111000010: w_dec_cls = C_LDUR;
                11'b11111000000: w_dec_cls = C_STUR;
                default:         w_dec_cls = C_ILL;
            endcase
        end
    end

    // status is {V,C,N,Z}
    always_comb begin
        w_cond = 1'b1;
        case (IR[3:0])
            4'h0: w_cond = status[0];
            4'h1: w_cond = !status[0];
            4'h2: w_cond = status[2];
            4'h3: w_cond = !status[2];
            4'h4: w_cond = status[1];
            4'h5: w_cond = !status[1];
            4'h6: w_cond = status[3];
            4'h7: w_cond = !status[3];
            4'h8: w_cond = status[2] & !status[0];
            4'h9: w_cond = !(status[2] & !status[0]);
            4'hA: w_cond = (status[1] == status[3]);
            4'hB: w_cond = (status[1] != status[3]);
            4'hC: w_cond = !status[0] & (status[1] == status[3]);
            4'hD: w_cond = !(!status[0] & (status[1] == status[3]));
            default: w_cond = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_cls   <= C_ILL;
        end else begin
            case (r_state)
                S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_cls   <= w_dec_cls;
                    r_state <= S_EX;
                end
                S_EX: begin
                    case (r_cls)
                        C_LDUR, C_STUR: r_state <= S_MEM;
                        C_CBZ:          r_state <= S_BR_TEST;
                        C_ILL:          r_state <= S_HALT;
                        default:        r_state <= S_FETCH;
                    endcase
                end
                S_MEM:     if (mem_ready) r_state <= S_FETCH;
                S_BR_TEST: r_state <= S_FETCH;
                S_HALT:    r_state <= S_HALT;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // PC only advances in an instruction's last cycle, so branch targets are relative to its own address.
    always_comb begin
        w_cw   = '0;
        w_k    = '0;
        w_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_cw.add_tri_sel  = 1'b1;
                w_cw.mem_cs       = MEM_CS_ROM;
                w_cw.size         = 2'b10;
                w_cw.data_tri_sel = 2'd3;
                w_cw.ir_load      = mem_ready;
            end
            S_EX: begin
                case (r_cls)
                    C_ADD, C_SUB, C_AND, C_ORR, C_ADDS, C_SUBS, C_ADDI, C_SUBI: begin
                        w_cw.sa    = IR[9:5];
                        w_cw.sb    = IR[20:16];
                        w_cw.da    = IR[4:0];
                        w_cw.w_reg = 1'b1;
                        w_cw.pc_fs = 2'b01;
                        w_done     = 1'b1;
                        case (r_cls)
                            C_SUB, C_SUBS, C_SUBI: begin
                                w_cw.fs = FS_SUB;
                                w_cw.c0 = 1'b1;
                            end
                            C_AND:   w_cw.fs = FS_AND;
                            C_ORR:   w_cw.fs = FS_ORR;
                            default: w_cw.fs = FS_ADD;
                        endcase
                        w_cw.status_load = (r_cls == C_ADDS) || (r_cls == C_SUBS);
                        if (r_cls == C_ADDI || r_cls == C_SUBI) begin
                            w_cw.b_sel = 1'b1;
                            w_k        = {52'd0, IR[21:10]};
                        end
                    end
                    C_B: begin
                        w_cw.pc_sel = 1'b1;
                        w_cw.pc_fs  = 2'b10;
                        w_k         = {{38{IR[25]}}, IR[25:0]};
                        w_done      = 1'b1;
                    end
                    C_CBZ: begin
                        w_cw.sb          = IR[4:0];
                        w_cw.fs          = FS_PASSB;
                        w_cw.status_load = 1'b1;
                    end
                    C_BCOND: begin
                        w_done = 1'b1;
                        if (w_cond) begin
                            w_cw.pc_sel = 1'b1;
                            w_cw.pc_fs  = 2'b10;
                            w_k         = {{45{IR[23]}}, IR[23:5]};
                        end else begin
                            w_cw.pc_fs = 2'b01;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                w_cw.sa     = IR[9:5];
                w_cw.b_sel  = 1'b1;
                w_cw.fs     = FS_ADD;
                w_cw.mem_cs = MEM_CS_RAM;
                w_cw.size   = 2'b11;
                w_k         = {{55{IR[20]}}, IR[20:12]};
                if (r_cls == C_LDUR) begin
                    w_cw.data_tri_sel = 2'd3;
                    w_cw.da           = IR[4:0];
                    w_cw.w_reg        = mem_ready;
                end else begin
                    w_cw.sb           = IR[4:0];
                    w_cw.data_tri_sel = 2'd1;
                    w_cw.mem_write_en = 1'b1;
                end
                if (mem_ready) begin
                    w_cw.pc_fs = 2'b01;
                    w_done     = 1'b1;
                end
            end
            S_BR_TEST: begin
                w_done = 1'b1;
                if (status[0]) begin
                    w_cw.pc_sel = 1'b1;
                    w_cw.pc_fs  = 2'b10;
                    w_k         = {{45{IR[23]}}, IR[23:5]};
                end else begin
                    w_cw.pc_fs = 2'b01;
                end
            end
            default: ;
        endcase
    end

    // Reset gates the outputs directly so no write strobe outlives its assertion.
    assign controlWord = reset ? w_cw : 36'd0;
    assign k           = reset ? w_k : 64'd0;
    assign instr_done  = reset & w_done;
    assign halted      = reset & (r_state == S_HALT);
endmodule

// File: tb/tb_legv8_control_fsm.sv
`timescale 1ns/1ps
// Directed bench for legv8_control_fsm: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_legv8_control_fsm;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] IR;
    logic [3:0]  status;
    logic        mem_ready;
    logic [35:0] controlWord;
    logic [63:0] k;
    logic        instr_done;
    logic        halted;

    legv8_control_fsm dut (
        .clock(clock), .reset(reset), .IR(IR), .status(status), .mem_ready(mem_ready),
        .controlWord(controlWord), .k(k), .instr_done(instr_done), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0] fs;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] da;
        logic       w_reg;
        logic       c0;
        logic [1:0] mem_cs;
        logic       b_sel;
        logic       mem_write_en;
        logic       ir_load;
        logic       status_load;
        logic [1:0] size;
        logic       add_tri_sel;
        logic [1:0] data_tri_sel;
        logic       pc_sel;
        logic [1:0] pc_fs;
    } cw_t;

    typedef struct {
        int          cyc;
        logic [35:0] cw;
        logic [63:0] kv;
        logic        done;
        logic        hlt;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Monitor: drains every expectation tagged with the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    chk({e.name, "_stale"}, 64'(cyc), 64'(e.cyc));
                end else begin
                    chk({e.name, "_cw"},   {28'd0, controlWord}, {28'd0, e.cw});
                    chk({e.name, "_k"},    k, e.kv);
                    chk({e.name, "_done"}, {63'd0, instr_done}, {63'd0, e.done});
                    chk({e.name, "_halt"}, {63'd0, halted}, {63'd0, e.hlt});
                end
            end
        end
    end

    task automatic expect_cyc(string name, cw_t cw, logic [63:0] kv, logic done, logic hlt);
        exp_t e;
        e.cyc = cyc; e.cw = cw; e.kv = kv; e.done = done; e.hlt = hlt; e.name = name;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    function automatic cw_t f_fetch(logic rdy);
        cw_t c = '0;
        c.add_tri_sel = 1'b1; c.mem_cs = 2'b10; c.size = 2'b10;
        c.data_tri_sel = 2'd3; c.ir_load = rdy;
        return c;
    endfunction

    function automatic cw_t f_alu(logic [4:0] fs, logic c0, logic sl, logic bsel,
                                  logic [4:0] sa, logic [4:0] sb, logic [4:0] da);
        cw_t c = '0;
        c.fs = fs; c.c0 = c0; c.status_load = sl; c.b_sel = bsel;
        c.sa = sa; c.sb = sb; c.da = da; c.w_reg = 1'b1; c.pc_fs = 2'b01;
        return c;
    endfunction

    function automatic cw_t f_mem(logic load, logic [4:0] sa, logic [4:0] rt, logic rdy);
        cw_t c = '0;
        c.fs = 5'b01000; c.sa = sa; c.b_sel = 1'b1; c.mem_cs = 2'b01; c.size = 2'b11;
        if (load) begin
            c.data_tri_sel = 2'd3; c.da = rt; c.w_reg = rdy;
        end else begin
            c.data_tri_sel = 2'd1; c.sb = rt; c.mem_write_en = 1'b1;
        end
        c.pc_fs = rdy ? 2'b01 : 2'b00;
        return c;
    endfunction

    function automatic cw_t f_br(logic taken);
        cw_t c = '0;
        c.pc_sel = taken;
        c.pc_fs  = taken ? 2'b10 : 2'b01;
        return c;
    endfunction

    function automatic cw_t f_cbz(logic [4:0] rt);
        cw_t c = '0;
        c.fs = 5'b10100; c.sb = rt; c.status_load = 1'b1;
        return c;
    endfunction

    typedef struct { logic [31:0] ir; logic [3:0] st; logic taken; } bc_t;
    bc_t bc_tab[9] = '{
        '{32'h54000080, 4'b0001, 1'b1},   // EQ, Z=1
        '{32'h54000080, 4'b0000, 1'b0},   // EQ, Z=0
        '{32'h5400008C, 4'b1010, 1'b1},   // GT, N=V, Z=0
        '{32'h5400008C, 4'b1011, 1'b0},   // GT, Z=1
        '{32'h54000083, 4'b0100, 1'b0},   // LO, C=1
        '{32'h54000088, 4'b0100, 1'b1},   // HI, C=1 Z=0
        '{32'h5400008B, 4'b1000, 1'b1},   // LT, N!=V
        '{32'h5400008E, 4'b0000, 1'b1},   // AL
        '{32'h54000081, 4'b0001, 1'b0}    // NE, Z=1
    };

    initial begin
        reset = 1'b0; IR = 32'h0; status = 4'h0; mem_ready = 1'b1;
        @(posedge clock); #1;
        expect_cyc("rst_a", '0, 64'd0, 1'b0, 1'b0);
        expect_cyc("rst_b", '0, 64'd0, 1'b0, 1'b0);
        reset = 1'b1;

        IR = 32'h8B020023;   // ADD X3,X1,X2
        expect_cyc("add_fetch", f_fetch(1'b1), 64'd0, 1'b0, 1'b0);
        expect_cyc("add_dec", '0, 64'd0, 1'b0, 1'b0);
        expect_cyc("add_ex", f_alu(5'b01000, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3), 64'd0, 1'b1, 1'b0);

        IR = 32'hEB020023;   // SUBS X3,X1,X2
        expect_cyc("subs_fetch", f_fetch(1'b1), 64'd0, 1'b0, 1'b0);
        expect_cyc("subs_dec", '0, 64'd0, 1'b0, 1'b0);
        expect_cyc("subs_ex", f_alu(5'b01001, 1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3), 64'd0, 1'b1, 1'b0);

        IR = 32'h913FFC41;   // ADDI X1,X2,#0xFFF
        expect_cyc("addi_fetch", f_fetch(1'b1), 64'd0, 1'b0, 1'b0);
        expect_cyc("addi_dec", '0, 64'd0, 1'b0, 1'b0);
        expect_cyc("addi_ex", f_alu(5'b01000, 1'b0, 1'b0, 1'b1, 5'd2, 5'd31, 5'd1), 64'hFFF, 1'b1, 1'b0);

        IR = 32'hF8408025;   // LDUR X5,[X1,#8], fetch stalls once, MEM stalls twice
        mem_ready = 1'b0;
        expect_cyc("ldur_fetch_wait", f_fetch(1'b0), 64'd0, 1'b0, 1'b0);
        mem_ready = 1'b1;
        expect_cyc("ldur_fetch", f_fetch(1'b1), 64'd0, 1'b0, 1'b0);
        expect_cyc("ldur_dec", '0, 64'd0, 1'b0, 1'b0);
        expect_cyc("ldur_ex", '0, 64'd0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        expect_cyc("ldur_mem_w0", f_mem(1'b1, 5'd1, 5'd5, 1'b0), 64'd8, 1'b0, 1'b0);
        expect_cyc("ldur_mem_w1", f_mem(1'b1, 5'd1, 5'd5, 1'b0), 64'd8, 1'b0, 1'b0);
        mem_ready = 1'b1;
        expect_cyc("ldur_mem_rdy", f_mem(1'b1, 5'd1, 5'd5, 1'b1), 64'd8, 1'b1, 1'b0);

        IR = 32'hF81FF027;   // STUR X7,[X1,#-1]
        expect_cyc("stur_fetch", f_fetch(1'b1), 64'd0, 1'b0, 1'b0);
        expect_cyc("stur_dec", '0, 64'd0, 1'b0, 1'b0);
        expect_cyc("stur_ex", '0, 64'd0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        expect_cyc("stur_mem_w", f_mem(1'b0, 5'd1, 5'd7, 1'b0), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        mem_ready = 1'b1;
        expect_cyc("stur_mem_rdy", f_mem(1'b0, 5'd1, 5'd7, 1'b1), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

        for (int t = 0; t < 2; t++) begin   // CBZ X4,#3: taken then not taken
            IR = 32'hB4000064;
            status = 4'b0001;
            expect_cyc("cbz_fetch", f_fetch(1'b1), 64'd0, 1'b0, 1'b0);
            expect_cyc("cbz_dec", '0, 64'd0, 1'b0, 1'b0);
            expect_cyc("cbz_ex", f_cbz(5'd4), 64'd0, 1'b0, 1'b0);
            status = (t == 0) ? 4'b0001 : 4'b0000;
            expect_cyc(t == 0 ? "cbz_taken" : "cbz_fall", f_br(t == 0),
                       (t == 0) ? 64'd3 : 64'd0, 1'b1, 1'b0);
        end

        for (int i = 0; i < 9; i++) begin
            IR = bc_tab[i].ir;
            status = bc_tab[i].st;
            expect_cyc($sformatf("bc%0d_fetch", i), f_fetch(1'b1), 64'd0, 1'b0, 1'b0);
            expect_cyc($sformatf("bc%0d_dec", i), '0, 64'd0, 1'b0, 1'b0);
            expect_cyc($sformatf("bc%0d_ex", i), f_br(bc_tab[i].taken),
                       bc_tab[i].taken ? 64'd4 : 64'd0, 1'b1, 1'b0);
        end

        IR = 32'h17FFFFFE;   // B #-2
        status = 4'b0000;
        expect_cyc("b_fetch", f_fetch(1'b1), 64'd0, 1'b0, 1'b0);
        expect_cyc("b_dec", '0, 64'd0, 1'b0, 1'b0);
        expect_cyc("b_ex", f_br(1'b1), 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);

        IR = 32'hF81FF027;   // STUR interrupted by reset in MEM
        expect_cyc("sturr_fetch", f_fetch(1'b1), 64'd0, 1'b0, 1'b0);
        expect_cyc("sturr_dec", '0, 64'd0, 1'b0, 1'b0);
        expect_cyc("sturr_ex", '0, 64'd0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        expect_cyc("sturr_mem", f_mem(1'b0, 5'd1, 5'd7, 1'b0), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        reset = 1'b0;
        expect_cyc("sturr_rst_a", '0, 64'd0, 1'b0, 1'b0);
        expect_cyc("sturr_rst_b", '0, 64'd0, 1'b0, 1'b0);
        reset = 1'b1;
        mem_ready = 1'b1;
        IR = 32'h0;          // after reset: fetch an illegal opcode
        expect_cyc("ill_fetch", f_fetch(1'b1), 64'd0, 1'b0, 1'b0);
        expect_cyc("ill_dec", '0, 64'd0, 1'b0, 1'b0);
        expect_cyc("ill_ex", '0, 64'd0, 1'b0, 1'b0);
        for (int h = 0; h < 10; h++) begin
            mem_ready = h[0];
            expect_cyc($sformatf("halt%0d", h), '0, 64'd0, 1'b0, 1'b1);
        end
        reset = 1'b0;
        expect_cyc("halt_rst", '0, 64'd0, 1'b0, 1'b0);
        reset = 1'b1;
        mem_ready = 1'b1;
        expect_cyc("post_halt_fetch", f_fetch(1'b1), 64'd0, 1'b0, 1'b0);

        @(negedge clock);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/legv8_control_fsm.md
Name: legv8_control_fsm

Overview:
- Multi-cycle control unit that sequences the LEGv8 datapath.
- Fetches each instruction over the shared bus into IR, decodes it, and drives the 36-bit datapath control word plus the 64-bit constant k.
- Waits on a memory ready handshake for every memory access.
- Sits between the instruction register/status register outputs and the datapath controlWord/k inputs.

Parameters:
- FS_ADD, 5'b01000, ALU function code for add.
- FS_SUB, 5'b01001, ALU function code for subtract; C0=1 is always driven with it.
- FS_AND, 5'b00000, ALU function code for AND.
- FS_ORR, 5'b00100, ALU function code for OR.
- FS_PASSB, 5'b10100, ALU function code for pass-through of B.
- MEM_CS_ROM, 2'b10, chip select for instruction memory.
- MEM_CS_RAM, 2'b01, chip select for data memory.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- IR, input, 32, instruction register contents.
- status, input, 4, registered flags {V,C,N,Z}.
- mem_ready, input, 1, memory has completed the current access this cycle.
- controlWord, output, 36, packed {FS,SA,SB,DA,w_reg,C0,mem_cs,B_Sel,mem_write_en,IR_load,status_load,size,add_tri_sel,data_tri_sel,PC_sel,PC_FS}.
- k, output, 64, sign/zero-extended constant.
- instr_done, output, 1, one-cycle pulse in the final cycle of each retired instruction.
- halted, output, 1, high in HALT.

Behaviour:
Field encodings:
- data_tri_sel: 0=ALU, 1=B, 2=PC4, 3=memory.
- add_tri_sel: 0=ALU, 1=PC.
- PC_FS: 00=hold, 01=PC+4, 10=PC+(in<<2), 11=load in.
- size: 10=32-bit, 11=64-bit.
- Default for every field not listed below is 0. k defaults to 0.

Reset:
- While reset=0: state=FETCH, controlWord=0, k=0, instr_done=0, halted=0. This is combinationally forced.
- Reset may arrive mid-instruction. The partial access is abandoned and no w_reg/mem_write_en pulse may survive the reset assertion.

PC update rule:
- PC is held (PC_FS=00) in every cycle except the last cycle of an instruction.
- Branch offsets are therefore relative to the instruction's own address.

FETCH:
- add_tri_sel=1, mem_cs=MEM_CS_ROM, size=10, data_tri_sel=3.
- IR_load = mem_ready.
- Stay in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.

DECODE:
- Idle control word (all 0). Register the instruction class. Next state is EX.

EX, R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, ADDS 10101011000, SUBS 11101011000):
- SA=IR[9:5], SB=IR[20:16], DA=IR[4:0], B_Sel=0, w_reg=1, data_tri_sel=0, PC_FS=01.
- status_load=1 only for ADDS/SUBS.
- Next state FETCH, instr_done=1.

EX, I-type (ADDI 1001000100, SUBI 1101000100):
- Same as R-type, but B_Sel=1 and k = zero-extended IR[21:10].

EX, LDUR (11111000010) and STUR (11111000000):
- No writes this cycle. Next state MEM.

MEM:
- SA=IR[9:5], B_Sel=1, k = sign-extended IR[20:12], FS=FS_ADD, add_tri_sel=0, mem_cs=MEM_CS_RAM, size=11.
- LDUR: data_tri_sel=3, DA=IR[4:0], w_reg=mem_ready.
- STUR: SB=IR[4:0], data_tri_sel=1, mem_write_en=1 held until mem_ready.
- On mem_ready=1: PC_FS=01, instr_done=1, next state FETCH. Otherwise stay in MEM with PC_FS=00.

EX, B (IR[31:26]=000101):
- PC_sel=1, k = sign-extended IR[25:0], PC_FS=10. Next state FETCH, instr_done=1.

EX, CBZ (IR[31:24]=10110100):
- SB=IR[4:0], B_Sel=0, FS=FS_PASSB, status_load=1. Next state BR_TEST.

BR_TEST:
- If status[0] (Z) = 1: PC_sel=1, k = sign-extended IR[23:5], PC_FS=10.
- Otherwise: PC_FS=01.
- instr_done=1, next state FETCH.

EX, B.cond (IR[31:24]=01010100, cond=IR[3:0]):
- Condition uses the registered status:
  - EQ 0: Z
  - NE 1: !Z
  - HS 2: C
  - LO 3: !C
  - MI 4: N
  - PL 5: !N
  - VS 6: V
  - VC 7: !V
  - HI 8: C&!Z
  - LS 9: !(C&!Z)
  - GE A: N==V
  - LT B: N!=V
  - GT C: !Z&(N==V)
  - LE D: !(!Z&(N==V))
  - AL E/F: 1
- Taken: PC_sel=1, k = sign-extended IR[23:5], PC_FS=10.
- Not taken: PC_FS=01.
- instr_done=1, next state FETCH.

Any other opcode:
- Go to HALT. PC_FS=00, no writes.
- HALT asserts halted=1 with an idle control word. Only reset exits HALT.

Latency with mem_ready tied high:
- ALU and branch instructions: 3 cycles.
- CBZ, LDUR, STUR: 4 cycles.

Test Plan:
- IR=0x8B020023 (ADD X3,X1,X2), mem_ready=1:
  - FETCH cycle: IR_load=1.
  - EX cycle: DA=3, SA=1, SB=2, w_reg=1, data_tri_sel=0, PC_FS=01, instr_done=1.
  - Total: 3 cycles.
- IR=0xF8408025 (LDUR X5,[X1,#8]), mem_ready low for 2 MEM cycles then high:
  - MEM holds w_reg=0 and PC_FS=00 for 2 cycles.
  - Then w_reg=1, DA=5, k=8, add_tri_sel=0, PC_FS=01.
- IR=0xB4000064 (CBZ X4,#3):
  - EX: status_load=1, FS=FS_PASSB, SB=4.
  - BR_TEST with status=4'b0001: k=3, PC_sel=1, PC_FS=10.
  - BR_TEST with status=4'b0000: PC_FS=01.
- IR=0x54000080 (B.EQ #4):
  - status Z=1: k=4, PC_FS=10.
  - status Z=0: PC_FS=01.
  - IR=0x17FFFFFE (B #-2): k=64'hFFFF_FFFF_FFFF_FFFE.
- IR=0x00000000:
  - Enters HALT, halted=1, controlWord=0 for 10 cycles.
  - Pulse reset=0: back in FETCH with halted=0.
- Assert reset=0 during a STUR MEM cycle:
  - mem_write_en drops to 0 in the same cycle (asynchronous).
  - After release the FSM is in FETCH.
